i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Byte-level register file sitting directly downstream of the rover's I2C slave (device address 0x55) inside the CPU comms stack. It turns the slave's received byte stream into pointer-addressed writes to control registers, and answers the slave's transmit requests with register contents. The read-only status values are snapshotted at each transaction start, so multi-byte reads are coherent. Register 0..NUM_RW-1 are read/write control outputs to the rover fabric; NUM_RW..NUM_REGS-1 are read-only status inputs.

## Interface
- NUM_RW, 8, number of read/write control registers (8 bits each)
- NUM_RO, 8, number of read-only status registers; NUM_RW+NUM_RO (NUM_REGS) must be a power of two, 2..256
- ADDR_W, $clog2(NUM_RW+NUM_RO), register pointer width (derived, not overridden)

- sclk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- i2c_start  in  1  one-cycle pulse: slave matched address 0x55 (start or repeated start)
- i2c_stop  in  1  one-cycle pulse: stop condition seen
- rx_valid  in  1  one-cycle pulse: master-written byte available
- rx_data  in  8  master-written byte, valid with rx_valid
- tx_req  in  1  one-cycle pulse: slave needs the next byte to send to master
- tx_data  out  8  byte to send; valid from tx_valid until next tx_req
- tx_valid  out  1  one-cycle pulse, exactly one cycle after tx_req
- status_in  in  8*NUM_RO  status values; byte k is register NUM_RW+k
- ctrl_out  out  8*NUM_RW  control register contents; byte k is register k
- wr_strobe  out  NUM_RW  one-cycle pulse per register written, aligned with ctrl_out update
- proto_err  out  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, PTR (awaiting pointer byte), DATA.
- IDLE: rx_valid ignored. tx_req answered normally (the slave only requests after an address match, so this is tolerance, not a use case). i2c_start -> PTR.
- Every i2c_start, in any state: status_in is captured into the snapshot bank, and the state goes to PTR. ptr is not changed.
- PTR + rx_valid: ptr <= rx_data[ADDR_W-1:0] (upper bits discarded, no error); -> DATA.
- DATA + rx_valid:
  - If ptr < NUM_RW: reg[ptr] <= rx_data and wr_strobe[ptr] pulses.
  - If ptr >= NUM_RW: the write is dropped and proto_err pulses.
  - In both cases ptr <= ptr+1, wrapping modulo NUM_REGS; state stays DATA.
- tx_req in PTR or DATA: tx_data <= (ptr < NUM_RW ? ctrl reg : snapshot) [ptr]; ptr <= ptr+1 (wrap); state -> DATA. A read after a repeated start without a pointer byte therefore continues from the retained ptr.
- i2c_stop: -> IDLE; ptr and all registers retained.
- Simultaneous events:
  - rx_valid with i2c_stop: the byte is processed first, then IDLE.
  - i2c_start with i2c_stop: start wins (-> PTR, snapshot taken).
  - rx_valid with tx_req: tx_req serviced, the rx byte is dropped, proto_err pulses, ptr advances once.
  - i2c_start with rx_valid: start wins and the byte is dropped.
- Reset (any time, including mid-transaction) forces:
  - state IDLE, ptr 0
  - ctrl_out all 0, snapshot all 0
  - tx_data 0x00, tx_valid 0, wr_strobe 0, proto_err 0
  - An in-flight read response is abandoned.

## Timing
- All state updates happen on the rising edge of sclk. Outputs are registered; there is no combinational path from inputs to outputs.
- Write latency: ctrl_out and wr_strobe change on the first edge after the rx_valid cycle (1 cycle).
- Read latency: tx_data and tx_valid appear 1 cycle after tx_req. tx_data holds until the next tx_req or reset.
- A write to reg[ptr] in cycle N is visible to a tx_req in cycle N+1 or later.
- The snapshot is taken on the edge that samples i2c_start. status_in changes after that edge are not visible until the next start.
- Back-to-back pulses every cycle must be supported: rx_valid on consecutive cycles, and tx_req on consecutive cycles.

## Test plan
- Write burst: start, rx 0x02, 0xAA, 0xBB, stop -> reg2=0xAA, reg3=0xBB; wr_strobe[2] then wr_strobe[3] pulse one cycle each; final ptr=4.
- Read with repeated start: start, rx 0x06, start, 3x tx_req -> tx_data reg6, reg7, then status byte 0 (reg8); each tx_valid arrives 1 cycle after its tx_req.
- Snapshot coherence: status_in byte0=0x11 at start; change it to 0x22 mid-read -> read returns 0x11. Next transaction returns 0x22.
- Wrap and read-only write: start, rx 0x0F, 0x55, 0x66 -> write to reg15 dropped with proto_err pulse; reg0=0x66; ptr wraps to 1.
- Collisions: rx_valid+tx_req in the same cycle -> proto_err, byte dropped, tx_valid next cycle. rx_valid+i2c_stop -> byte written, then IDLE. rx_valid while IDLE -> ignored.
- Reset mid-burst: assert rst asynchronously between sclk edges after 2 data bytes -> ctrl_out=0, tx_valid=0, ptr=0 immediately. The next transaction behaves as after power-up.

Source files
------------

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: pointer-addressed register file behind the rover's I2C slave (address 0x55).
// Registers 0..NUM_RW-1 are read/write control bytes driven to the fabric; registers
// NUM_RW..NUM_REGS-1 read back a snapshot of status_in taken at each (repeated) start.
module i2c_reg_bank #(
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 8
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                i2c_start,
  input  logic                i2c_stop,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                tx_req,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic [8*NUM_RO-1:0] status_in,
  output logic [8*NUM_RW-1:0] ctrl_out,
  output logic [NUM_RW-1:0]   wr_strobe,
  output logic                proto_err
);

  localparam int NUM_REGS = NUM_RW + NUM_RO;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [7:0]        ctrl [NUM_RW];
  logic [7:0]        snap [NUM_RO];
  logic [7:0]        rd_byte;
  logic              ptr_is_rw;
  logic              rx_take;
  logic              do_ptr;
  logic              do_data;
  logic              do_wr;
  logic              do_err;

  assign ptr_is_rw = ({1'b0, ptr} < (ADDR_W+1)'(NUM_RW));

  // Read mux: live control byte or status snapshot selected by ptr.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_RW; i++) begin
      if (ptr == ADDR_W'(i)) begin
        rd_byte = ctrl[i];
      end else begin
        rd_byte = rd_byte;
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (ptr == ADDR_W'(NUM_RW + k)) begin
        rd_byte = snap[k];
      end else begin
        rd_byte = rd_byte;
      end
    end
  end

  // Event decode: start drops rx bytes, tx_req beats rx_valid, IDLE ignores rx bytes.
  always_comb begin
    rx_take = rx_valid && !i2c_start && (state != IDLE);
    do_ptr  = rx_take && !tx_req && (state == PTR);
    do_data = rx_take && !tx_req && (state == DATA);
    do_wr   = do_data && ptr_is_rw;
    do_err  = (rx_take && tx_req) || (do_data && !ptr_is_rw);
    if (do_ptr) begin
      ptr_nxt = ADDR_W'(rx_data);
    end else if (tx_req || do_data) begin
      ptr_nxt = ptr + ADDR_W'(1);
    end else begin
      ptr_nxt = ptr;
    end
  end

  // Next-state logic: start beats stop, stop applies after the cycle's byte is handled.
  always_comb begin
    state_nxt = state;
    if (i2c_start) begin
      state_nxt = PTR;
    end else if (i2c_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        PTR:     state_nxt = (tx_req || rx_valid) ? DATA : PTR;
        DATA:    state_nxt = DATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: pointer, control bytes, snapshot and all registered outputs.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      proto_err <= 1'b0;
      wr_strobe <= '0;
      for (int i = 0; i < NUM_RW; i++) ctrl[i] <= 8'h00;
      for (int k = 0; k < NUM_RO; k++) snap[k] <= 8'h00;
    end else begin
      ptr       <= ptr_nxt;
      tx_valid  <= tx_req;
      proto_err <= do_err;
      if (tx_req) begin
        tx_data <= rd_byte;
      end
      for (int i = 0; i < NUM_RW; i++) begin
        wr_strobe[i] <= do_wr && (ptr == ADDR_W'(i));
        if (do_wr && (ptr == ADDR_W'(i))) begin
          ctrl[i] <= rx_data;
        end
      end
      if (i2c_start) begin
        for (int k = 0; k < NUM_RO; k++) snap[k] <= status_in[8*k +: 8];
      end
    end
  end

  // Flatten the control bytes onto the fabric bus.
  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_RW; i++) ctrl_out[8*i +: 8] = ctrl[i];
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed table plus random traffic against a behavioural model.
module tb_i2c_reg_bank;

  localparam int NRW = 8;
  localparam int NRO = 8;
  localparam int NREG = NRW + NRO;

  logic            sclk = 1'b0;
  logic            rst = 1'b1;
  logic            i2c_start = 1'b0;
  logic            i2c_stop = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_req = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic [8*NRO-1:0] status_in = '0;
  logic [8*NRW-1:0] ctrl_out;
  logic [NRW-1:0]  wr_strobe;
  logic            proto_err;

  int n_vec = 0;
  int n_err = 0;

  i2c_reg_bank #(.NUM_RW(NRW), .NUM_RO(NRO)) dut (
    .sclk(sclk), .rst(rst), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .tx_data(tx_data),
    .tx_valid(tx_valid), .status_in(status_in), .ctrl_out(ctrl_out),
    .wr_strobe(wr_strobe), .proto_err(proto_err)
  );

  // Free-running system clock.
  always #5 sclk = ~sclk;

  // Behavioural model: bus open/closed, pointer expected, register arrays.
  logic [7:0] m_ctrl [NRW];
  logic [7:0] m_snap [NRO];
  int         m_ptr = 0;
  bit         m_open = 1'b0;
  bit         m_want_ptr = 1'b0;
  logic [7:0] m_strb = 8'h00;
  bit         m_err = 1'b0;
  bit         m_txv = 1'b0;
  logic [7:0] m_txd = 8'h00;

  typedef struct {
    bit st; bit sp; bit rv; logic [7:0] rd; bit tr; logic [7:0] s0;
    logic [7:0] e_strb; bit e_err; bit e_txv; logic [7:0] e_txd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit sp, bit rv, logic [7:0] rd, bit tr, logic [7:0] s0,
                              logic [7:0] e_strb, bit e_err, bit e_txv, logic [7:0] e_txd);
    vec_t v;
    v.st = st; v.sp = sp; v.rv = rv; v.rd = rd; v.tr = tr; v.s0 = s0;
    v.e_strb = e_strb; v.e_err = e_err; v.e_txv = e_txv; v.e_txd = e_txd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_ctrl();
    logic [63:0] r = 64'h0;
    for (int i = 0; i < NRW; i++) r[8*i +: 8] = m_ctrl[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) m_ctrl[i] = 8'h00;
    for (int k = 0; k < NRO; k++) m_snap[k] = 8'h00;
    m_ptr = 0; m_open = 1'b0; m_want_ptr = 1'b0;
    m_strb = 8'h00; m_err = 1'b0; m_txv = 1'b0; m_txd = 8'h00;
  endtask

  // One cycle of the protocol rules, evaluated with the pre-edge register contents.
  task automatic model_cycle(bit st, bit sp, bit rv, logic [7:0] rd, bit tr, logic [63:0] stat);
    m_strb = 8'h00; m_err = 1'b0; m_txv = 1'b0;
    if (tr) begin
      m_txv = 1'b1;
      m_txd = (m_ptr < NRW) ? m_ctrl[m_ptr] : m_snap[m_ptr - NRW];
      m_ptr = (m_ptr + 1) % NREG;
    end
    if (rv && !st && m_open) begin
      if (tr) begin
        m_err = 1'b1;
      end else if (m_want_ptr) begin
        m_ptr = rd % NREG;
        m_want_ptr = 1'b0;
      end else begin
        if (m_ptr < NRW) begin
          m_ctrl[m_ptr] = rd;
          m_strb[m_ptr] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_ptr = (m_ptr + 1) % NREG;
      end
    end
    if (tr && m_open) m_want_ptr = 1'b0;
    if (st) begin
      for (int k = 0; k < NRO; k++) m_snap[k] = stat[8*k +: 8];
      m_open = 1'b1;
      m_want_ptr = 1'b1;
    end else if (sp) begin
      m_open = 1'b0;
      m_want_ptr = 1'b0;
    end
  endtask

  task automatic step(bit st, bit sp, bit rv, logic [7:0] rd, bit tr, logic [63:0] stat);
    i2c_start = st; i2c_stop = sp; rx_valid = rv; rx_data = rd; tx_req = tr; status_in = stat;
    model_cycle(st, sp, rv, rd, tr, stat);
    @(posedge sclk);
    #1;
    chk("model_ctrl", ctrl_out, model_ctrl());
    chk("model_strobe", 64'(wr_strobe), 64'(m_strb));
    chk("model_err", 64'(proto_err), 64'(m_err));
    chk("model_txv", 64'(tx_valid), 64'(m_txv));
    chk("model_txd", 64'(tx_data), 64'(m_txd));
    i2c_start = 1'b0; i2c_stop = 1'b0; rx_valid = 1'b0; tx_req = 1'b0;
  endtask

  initial begin
    model_reset();
    // Directed rows: st sp rv rd tr s0 | strobe err txv txd
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00)); // write burst
    tbl.push_back(mk(0, 0, 1, 8'h02, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 8'h11, 8'h04, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hBB, 0, 8'h11, 8'h08, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h33, 0, 8'h11, 8'h00, 0, 0, 8'h00)); // idle byte ignored
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00)); // ptr retained at 4
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h11, 8'h00, 0, 1, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h5A, 0, 8'h11, 8'h20, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00)); // fill reg6/7
    tbl.push_back(mk(0, 0, 1, 8'h06, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hC6, 0, 8'h11, 8'h40, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'hC7, 0, 8'h11, 8'h80, 0, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00)); // read, repeated start
    tbl.push_back(mk(0, 0, 1, 8'h06, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h11, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h11, 8'h00, 0, 1, 8'hC6));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h00, 0, 1, 8'hC7));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h00, 0, 1, 8'h11)); // coherent snapshot
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h11));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h11)); // new snapshot
    tbl.push_back(mk(0, 0, 1, 8'h08, 0, 8'h22, 8'h00, 0, 0, 8'h11));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h00, 0, 1, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h22));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h22)); // wrap + RO write
    tbl.push_back(mk(0, 0, 1, 8'h0F, 0, 8'h22, 8'h00, 0, 0, 8'h22));
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 8'h22, 8'h00, 1, 0, 8'h22));
    tbl.push_back(mk(0, 0, 1, 8'h66, 0, 8'h22, 8'h01, 0, 0, 8'h22));
    tbl.push_back(mk(0, 0, 1, 8'h77, 0, 8'h22, 8'h02, 0, 0, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h22));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h22)); // collisions
    tbl.push_back(mk(0, 0, 1, 8'h03, 0, 8'h22, 8'h00, 0, 0, 8'h22));
    tbl.push_back(mk(0, 0, 1, 8'h99, 1, 8'h22, 8'h00, 1, 1, 8'hBB));
    tbl.push_back(mk(0, 1, 1, 8'h44, 0, 8'h22, 8'h10, 0, 0, 8'hBB));
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 8'h22, 8'h00, 0, 0, 8'hBB));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'hBB)); // start beats stop
    tbl.push_back(mk(0, 0, 1, 8'h07, 0, 8'h22, 8'h00, 0, 0, 8'hBB));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h00, 0, 1, 8'hC7));
    tbl.push_back(mk(1, 0, 1, 8'h12, 0, 8'h22, 8'h00, 0, 0, 8'hC7)); // start beats rx
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'hC7));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h00, 0, 1, 8'h66));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 8'h22, 8'h00, 0, 0, 8'h66));

    repeat (2) @(posedge sclk);
    #1;
    chk("reset_ctrl", ctrl_out, 64'h0);
    chk("reset_txv", 64'(tx_valid), 64'h0);
    chk("reset_txd", 64'(tx_data), 64'h0);
    chk("reset_strobe", 64'(wr_strobe), 64'h0);
    chk("reset_err", 64'(proto_err), 64'h0);
    rst = 1'b0;

    foreach (tbl[n]) begin
      step(tbl[n].st, tbl[n].sp, tbl[n].rv, tbl[n].rd, tbl[n].tr, {56'h0, tbl[n].s0});
      chk($sformatf("tbl%0d_strobe", n), 64'(wr_strobe), 64'(tbl[n].e_strb));
      chk($sformatf("tbl%0d_err", n), 64'(proto_err), 64'(tbl[n].e_err));
      chk($sformatf("tbl%0d_txv", n), 64'(tx_valid), 64'(tbl[n].e_txv));
      if (tbl[n].e_txv) chk($sformatf("tbl%0d_txd", n), 64'(tx_data), 64'(tbl[n].e_txd));
    end
    chk("tbl_final_ctrl", ctrl_out, 64'hC7C65A44BBAA7766);

    // Randomised traffic, checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
           8'($urandom), $urandom_range(0, 3) == 0, {$urandom, $urandom});
    end

    // Reset mid-burst, asserted between clock edges with a read response live.
    step(1, 0, 0, 8'h00, 0, 64'h0);
    step(0, 0, 1, 8'h02, 0, 64'h0);
    step(0, 0, 1, 8'h11, 0, 64'h0);
    step(0, 0, 1, 8'h22, 0, 64'h0);
    step(0, 0, 0, 8'h00, 1, 64'h0);
    chk("prerst_txv", 64'(tx_valid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", ctrl_out, 64'h0);
    chk("midrst_txv", 64'(tx_valid), 64'h0);
    chk("midrst_txd", 64'(tx_data), 64'h0);
    model_reset();
    @(posedge sclk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 8'h00, 0, 64'h0);
    step(0, 0, 0, 8'h00, 1, 64'h0);
    chk("postrst_txd", 64'(tx_data), 64'h0);
    step(0, 0, 1, 8'h77, 0, 64'h0);
    chk("postrst_ptr_write", ctrl_out, 64'h7700);
    chk("postrst_strobe", 64'(wr_strobe), 64'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
